// File: rtl/oprom_pkg.sv
// ----------------------------------------------------------------------------
// oprom_pkg -- shared definitions for the two-port ROM read arbiter.
//   OPROM_ADDR_W      : default ROM word-address width
//   OPROM_DATA_W      : default ROM data width
//   OPROM_INIT_CYCLES : default cycles the ROM is held in reset after reset_n
//   oprom_state_t     : arbiter FSM state (ST_INIT while the ROM initialises,
//                       ST_READY afterwards)
// ----------------------------------------------------------------------------
package oprom_pkg;

  localparam int OPROM_ADDR_W      = 3;
  localparam int OPROM_DATA_W      = 8;
  localparam int OPROM_INIT_CYCLES = 2;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } oprom_state_t;

endpackage : oprom_pkg

// File: rtl/oprom_arb_pick.sv
// ----------------------------------------------------------------------------
// oprom_arb_pick -- two-way arbitration decision (purely combinational).
//   i_req [1:0] : requests, bit 0 = requester 0, bit 1 = requester 1
//   i_ptr       : requester that has priority on a collision
//   o_gnt [1:0] : one-hot (or zero) grant
// A lone request always wins regardless of i_ptr; i_ptr only matters when
// both requesters ask in the same cycle.
// ----------------------------------------------------------------------------
module oprom_arb_pick (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_ptr) begin
      if (i_req[1])      o_gnt = 2'b10;
      else if (i_req[0]) o_gnt = 2'b01;
    end else begin
      if (i_req[0])      o_gnt = 2'b01;
      else if (i_req[1]) o_gnt = 2'b10;
    end
  end

endmodule : oprom_arb_pick

// File: rtl/oprom_arb.sv
// ----------------------------------------------------------------------------
// oprom_arb -- shares one single-port ROM between two read requesters.
//
// After reset_n is released the ROM is held in synchronous reset for
// INIT_CYCLES cycles (INIT), then the block accepts one read per cycle
// (READY). Grants are combinational from the requests so a requester can be
// serviced every cycle; the ROM answers one cycle later and the matching
// rvalidX marks the shared rdata bus.
//
// Arbitration policy is selected at build time:
//   OPROM_ARB_RR_EN defined   : round-robin, the requester not granted last
//                               wins a collision
//   OPROM_ARB_RR_EN undefined : fixed priority, requester 0 always wins
//
// Parameters: ADDR_W (ROM word address), DATA_W (ROM data), INIT_CYCLES (>=1)
// Ports:
//   clk, reset_n            clock, async active-low reset
//   req0/1, addr0/1         read requests and word addresses
//   gnt0/1                  request accepted this cycle
//   rvalid0/1, rdata        read response (rdata shared, held between reads)
//   rom_ce, rom_oce,        ROM clock enable, output enable (tied 1),
//   rom_reset, rom_ad       synchronous reset and word address
//   rom_dout                ROM data, valid the cycle after a rom_ce edge
// ----------------------------------------------------------------------------
module oprom_arb
  import oprom_pkg::*;
#(
  parameter int ADDR_W      = OPROM_ADDR_W,
  parameter int DATA_W      = OPROM_DATA_W,
  parameter int INIT_CYCLES = OPROM_INIT_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic              rom_reset,
  output logic [ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_dout
);

  // Counter runs 0..INIT_LAST while in INIT; the FSM leaves INIT on the edge
  // where the counter reaches INIT_LAST, giving exactly INIT_CYCLES cycles.
  localparam int INIT_LAST = (INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0;
  localparam int CNT_W     = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  oprom_state_t      r_state;
  logic [CNT_W-1:0]  r_init_cnt;
  logic              r_rom_reset;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata;

  logic              w_ready;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_ptr;

  // --------------------------------------------------------------------------
  // INIT -> READY sequencer; rom_reset is registered alongside the state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_rom_reset <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == CNT_W'(INIT_LAST)) begin
            r_state     <= ST_READY;
            r_rom_reset <= 1'b0;
          end else begin
            r_init_cnt  <= r_init_cnt + CNT_W'(1);
          end
        end
        ST_READY: begin
          r_rom_reset <= 1'b0;
        end
        default: begin
          r_state     <= ST_INIT;
          r_rom_reset <= 1'b1;
        end
      endcase
    end
  end

  assign w_ready = (r_state == ST_READY);

  // Requests are masked in INIT so no grant (and no ROM access) can occur
  // while the ROM is still in reset.
  assign w_req = {req1, req0} & {2{w_ready}};

  // --------------------------------------------------------------------------
  // Arbitration pointer: names the requester that wins the next collision.
  // --------------------------------------------------------------------------
`ifdef OPROM_ARB_RR_EN
  logic r_ptr;

  // Only a grant moves the pointer; the winner drops to lowest priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= 1'b0;
    end else if (w_gnt[0]) begin
      r_ptr <= 1'b1;
    end else if (w_gnt[1]) begin
      r_ptr <= 1'b0;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = 1'b0;
`endif

  oprom_arb_pick u_pick (
    .i_req (w_req),
    .i_ptr (w_ptr),
    .o_gnt (w_gnt)
  );

  assign gnt0    = w_gnt[0];
  assign gnt1    = w_gnt[1];
  assign rom_ce  = w_gnt[0] | w_gnt[1];
  assign rom_oce = 1'b1;
  assign rom_ad  = w_gnt[0] ? addr0 :
                   w_gnt[1] ? addr1 : '0;
  assign rom_reset = r_rom_reset;

  // --------------------------------------------------------------------------
  // Response path: rvalid is the grant delayed by one cycle, matching the
  // ROM latency. rdata passes rom_dout through while valid and otherwise
  // replays the last valid word from r_rdata.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt[0];
      r_rvalid1 <= w_gnt[1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (r_rvalid0 | r_rvalid1) begin
      r_rdata <= rom_dout;
    end
  end

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata   = (r_rvalid0 | r_rvalid1) ? rom_dout : r_rdata;

endmodule : oprom_arb

// File: tb/tb_oprom_arb.sv
// ----------------------------------------------------------------------------
// tb_oprom_arb -- directed bench for oprom_arb with a scoreboard.
// Stimulus drives one cycle at a time, checks the combinational grant side
// and pushes the expected read response; a monitor on the falling edge pops
// and compares every response and checks the per-cycle invariants.
// ROM model: rom_dout = 8'hA0 | rom_ad, one cycle after a rom_ce edge.
// ----------------------------------------------------------------------------
module tb_oprom_arb;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b1;
  logic          req0    = 1'b0;
  logic          req1    = 1'b0;
  logic [AW-1:0] addr0   = '0;
  logic [AW-1:0] addr1   = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic          rom_ce, rom_oce, rom_reset;
  logic [DW-1:0] rdata;
  logic [AW-1:0] rom_ad;
  logic [DW-1:0] rom_dout = '0;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic          who;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];

  oprom_arb #(.ADDR_W(AW), .DATA_W(DW), .INIT_CYCLES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .rom_ce    (rom_ce),
    .rom_oce   (rom_oce),
    .rom_reset (rom_reset),
    .rom_ad    (rom_ad),
    .rom_dout  (rom_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_ce) rom_dout <= 8'hA0 | {5'b0, rom_ad};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic          prev_g0  = 1'b0;
  logic          prev_g1  = 1'b0;
  logic [DW-1:0] last_dat = '0;

  always @(negedge clk) begin
    exp_t e;
    chk("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
    chk("rom_ce", {31'd0, rom_ce}, {31'd0, gnt0 | gnt1});
    chk("rom_oce", {31'd0, rom_oce}, 32'd1);
    if (!reset_n) begin
      chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      chk("rst_rdata", {24'd0, rdata}, 32'd0);
      prev_g0  = 1'b0;
      prev_g1  = 1'b0;
      last_dat = '0;
    end else begin
      chk("rvalid0_trail", {31'd0, rvalid0}, {31'd0, prev_g0});
      chk("rvalid1_trail", {31'd0, rvalid1}, {31'd0, prev_g1});
      if (rvalid0 | rvalid1) begin
        if (q.size() == 0) begin
          chk("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rv_who", {31'd0, rvalid1}, {31'd0, e.who});
          chk("rdata", {24'd0, rdata}, {24'd0, e.data});
          last_dat = e.data;
        end
      end else begin
        chk("rdata_hold", {24'd0, rdata}, {24'd0, last_dat});
      end
      prev_g0 = gnt0;
      prev_g1 = gnt1;
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1; drives one cycle, checks at the falling edge,
  // returns at the next posedge+1.
  task automatic cyc(input logic r0, input logic [AW-1:0] a0,
                     input logic r1, input logic [AW-1:0] a1,
                     input logic eg0, input logic eg1, input logic erst);
    exp_t e;
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    @(negedge clk);
    chk("gnt0", {31'd0, gnt0}, {31'd0, eg0});
    chk("gnt1", {31'd0, gnt1}, {31'd0, eg1});
    chk("rom_reset", {31'd0, rom_reset}, {31'd0, erst});
    chk("rom_ad", {29'd0, rom_ad}, {29'd0, eg0 ? a0 : eg1 ? a1 : 3'd0});
    if (eg0 | eg1) begin
      e.who  = eg1;
      e.data = 8'hA0 | {5'b0, (eg0 ? a0 : a1)};
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic erst);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, erst);
  endtask

  // Holds reset over one rising edge with both requests high (they must be
  // ignored), releases at posedge+1.
  task automatic apply_reset();
    reset_n = 1'b0;
    req0 = 1'b1; addr0 = 3'd5; req1 = 1'b1; addr1 = 3'd6;
    q.delete();
    @(negedge clk);
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst_rom_reset", {31'd0, rom_reset}, 32'd1);
    chk("rst_rom_ad", {29'd0, rom_ad}, 32'd0);
    @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    #1;
    apply_reset();

    // First read after reset: two INIT cycles, grant in cycle 3, data in 4.
    cyc(1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Both requesters held for four cycles from a fresh pointer.
    apply_reset();
    idle(2, 1'b1);
`ifdef OPROM_ARB_RR_EN
    cyc(1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 3'd1, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 3'd1, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0);
`else
    for (int i = 0; i < 4; i++) cyc(1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
`endif
    idle(1, 1'b0);

    // Requester 1 alone, back to back.
    for (int i = 0; i < 3; i++) cyc(1'b0, 3'd0, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);

    // Requester 0 alone twice: served even right after its own grant.
    for (int i = 0; i < 2; i++) cyc(1'b1, 3'd2, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);

    // Collision then the loser keeps requesting until served.
`ifdef OPROM_ARB_RR_EN
    cyc(1'b1, 3'd4, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 3'd4, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
`else
    cyc(1'b1, 3'd4, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0);
`endif
    idle(2, 1'b0);

    // Reset pulsed the cycle after a grant: response is cancelled.
    cyc(1'b1, 3'd2, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    req0 = 1'b0;
    q.delete();
    @(negedge clk);
    chk("pulse_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("pulse_rdata", {24'd0, rdata}, 32'd0);
    chk("pulse_rom_reset", {31'd0, rom_reset}, 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 3'd4, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);

    chk("q_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_oprom_arb

// File: doc/oprom_arb.md
OPROM_ARB -- requirements
Module: oprom_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, ROM word-address width.
REQ-002 SHALL have parameter DATA_W, default 8, ROM data width.
REQ-003 SHALL have parameter INIT_CYCLES, default 2, cycles rom_reset is held after reset release.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports req0/req1  input  1  read request from requester 0/1.
REQ-007 SHALL have ports addr0/addr1  input  ADDR_W  ROM word address of requester 0/1.
REQ-008 SHALL have ports gnt0/gnt1  output  1  request accepted this cycle.
REQ-009 SHALL have ports rvalid0/rvalid1  output  1  rdata valid for requester 0/1.
REQ-010 SHALL have port rdata  output  DATA_W  read data, shared by both requesters.
REQ-011 SHALL have ports rom_ce, rom_oce, rom_reset  output  1  ROM clock-enable, output-enable, synchronous reset.
REQ-012 SHALL have port rom_ad  output  ADDR_W  ROM word address.
REQ-013 SHALL have port rom_dout  input  DATA_W  ROM read data, valid one cycle after a rom_ce=1 edge (bypass read).

Function
REQ-014 SHALL implement FSM INIT -> READY; INIT lasts exactly INIT_CYCLES cycles after reset_n deassertion, then READY permanently.
REQ-015 SHALL in INIT drive rom_reset=1, gnt0=gnt1=0, rom_ce=0; in READY rom_reset=0.
REQ-016 SHALL in READY grant at most one requester per cycle; gnt is combinational from req and arbitration state; gnt0 and gnt1 never both 1.
REQ-017 SHALL drive rom_ad = addr of granted requester, rom_ce = gnt0|gnt1, rom_ad = 0 when no grant.
REQ-018 SHALL tie rom_oce = 1.
REQ-019 SHALL register the grant: rvalidX = 1 in cycle N+1 exactly when gntX = 1 in cycle N; otherwise 0.
REQ-020 SHALL drive rdata = rom_dout when rvalid0|rvalid1, else hold the last valid value.
REQ-021 SHALL sustain one grant per cycle (back-to-back, no bubbles) while any req is high.
REQ-022 Requester SHALL hold req and addr stable until gnt; a req dropped before gnt is discarded without side effects.
REQ-023 SHALL service a single active requester every cycle regardless of arbitration state.

Reset
REQ-024 SHALL on reset_n=0 asynchronously force: FSM=INIT, init counter=0, gnt0=gnt1=0, rvalid0=rvalid1=0, rdata=0, rom_ce=0, rom_ad=0, rom_reset=1, round-robin pointer=requester 0.
REQ-025 Reset asserted mid-read SHALL cancel the pending rvalid; no rvalid after reset release before a new grant.

Configuration
REQ-026 With OPROM_ARB_RR_EN defined: round-robin; on simultaneous req0 and req1 the requester not granted last wins; pointer updates only on a grant.
REQ-027 Without OPROM_ARB_RR_EN: fixed priority, req0 always beats req1; no pointer register.

Structure
REQ-028 Shared package oprom_pkg SHALL hold ADDR_W/DATA_W defaults, INIT_CYCLES default, and the FSM state typedef (INIT, READY).
REQ-029 Arbitration SHALL be one sub-module oprom_arb_pick (req pair + pointer -> one-hot grant); the rest stays in oprom_arb.

Verification (bench ROM model: rom_dout = 8'hA0 | ad, one-cycle latency)
REQ-030 Reset release, req0=1 addr0=3 -> gnt0=0 for 2 cycles, rom_reset=1 for 2 cycles; gnt0=1 in cycle 3; rvalid0=1, rdata=8'hA3 in cycle 4.
REQ-031 req0 addr0=1 and req1 addr1=5 held 4 cycles, RR_EN -> grants 0,1,0,1; rdata sequence A1,A5,A1,A5 with matching rvalid.
REQ-032 Same stimulus without RR_EN -> gnt0 every cycle, gnt1 never, rdata A1 each cycle.
REQ-033 req1 alone addr1=7 for 3 cycles -> gnt1 each cycle, rvalid1 3 consecutive cycles, rdata=8'hA7.
REQ-034 reset_n pulsed low in the cycle after gnt0 -> rvalid0 stays 0, rdata=0, FSM re-enters INIT for 2 cycles.
REQ-035 All scenarios SHALL check: gnt0&gnt1 never 1; rom_ce==gnt0|gnt1; rvalid trails gnt by exactly one cycle.
